// File: rtl/alu_div_seq_if.sv
// Request/result bundle between the microsequencer and the sequential divider.
// The requester drives start and the operands; the divider returns status, R and flags.
interface alu_div_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] R;
  logic [3:0]  flags;

  modport master (
    output start, dividend, divisor,
    input  busy, done, R, flags
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, R, flags
  );
endinterface

// File: rtl/alu_div_seq.sv
// Unsigned restoring divider, 16-bit dividend by 8-bit divisor, STEPS_PER_CYCLE
// iterations per clock. Returns {remainder, quotient} with {S,V,C,Z} flags.
module alu_div_seq #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_div_seq_if.slave bus
);
  localparam int NITER = 8 / STEPS_PER_CYCLE;

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
      STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
    $error("alu_div_seq: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] rem;
  logic [7:0] q;
  logic [7:0] dvs;
  logic [7:0] rem_nxt;
  logic [7:0] q_nxt;

  // Unrolled restoring iterations performed in one RUN cycle.
  always_comb begin
    logic [8:0] t;
    t       = '0;
    rem_nxt = rem;
    q_nxt   = q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      t     = {rem_nxt, q_nxt[7]};
      q_nxt = {q_nxt[6:0], 1'b0};
      if (t >= {1'b0, dvs}) begin
        rem_nxt  = 8'(t - {1'b0, dvs});
        q_nxt[0] = 1'b1;
      end else begin
        rem_nxt = t[7:0];
      end
    end
  end

  // busy/done are registered from the state being left, so each lags its state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.R     <= '0;
      bus.flags <= '0;
    end else begin
      bus.busy <= (state == RUN);
      bus.done <= (state == FIN);
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvs <= bus.divisor;
            // Zero divisor also satisfies the high-byte test, so both share the saturated result.
            if (bus.dividend[15:8] >= bus.divisor) begin
              bus.R     <= bus.dividend;
              bus.flags <= 4'b1100;
              state     <= FIN;
            end else begin
              rem   <= bus.dividend[15:8];
              q     <= bus.dividend[7:0];
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(NITER - 1)) begin
            bus.R     <= {rem_nxt, q_nxt};
            bus.flags <= {q_nxt[7], 1'b0, 1'b0, ({rem_nxt, q_nxt} == 16'h0000)};
            state     <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: four instances (1/2/4/8 steps per cycle) share one stimulus
// stream; a transaction-level model predicts every output on every cycle.
module tb_alu_div_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  int          checks = 0;
  int          errors = 0;
  bit          run_chk = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SPC = 1 << g;
    localparam int NIT = 8 / SPC;

    alu_div_seq_if bus ();
    assign bus.start    = start;
    assign bus.dividend = dividend;
    assign bus.divisor  = divisor;

    alu_div_seq #(.STEPS_PER_CYCLE(SPC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Model: an accepted request finishes at a known edge; the result comes from / and %.
    longint      e = 0, acc = 0, done_at = -1, r_at = -1;
    bit          act = 1'b0, normal = 1'b0;
    logic [15:0] r_exp = '0, r_new = '0;
    logic [3:0]  f_exp = '0, f_new = '0;
    int          ndone = 0;
    logic        exp_busy, exp_done;

    always @(posedge clk) begin
      int qv, rv;
      e++;
      if (reset) begin
        act   = 1'b0;
        r_exp = '0;
        f_exp = '0;
      end else begin
        if (act && normal && e == r_at) begin
          r_exp = r_new;
          f_exp = f_new;
        end
        if ((!act || e > done_at) && start) begin
          acc = e;
          act = 1'b1;
          if (divisor == 8'h00 || int'(dividend) / 256 >= int'(divisor)) begin
            normal  = 1'b0;
            r_exp   = dividend;
            f_exp   = 4'b1100;
            done_at = e + 1;
          end else begin
            normal  = 1'b1;
            qv      = int'(dividend) / int'(divisor);
            rv      = int'(dividend) % int'(divisor);
            r_new   = {rv[7:0], qv[7:0]};
            f_new   = {qv[7], 2'b00, (r_new == 16'h0000)};
            r_at    = e + NIT;
            done_at = e + NIT + 1;
          end
        end
      end
    end

    assign exp_busy = act && normal && (e > acc) && (e <= acc + NIT);
    assign exp_done = act && (e == done_at);

    always @(negedge clk) if (bus.done === 1'b1) ndone++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmp_inst(input int idx, input logic b, input logic d, input logic [15:0] r,
                          input logic [3:0] f, input logic eb, input logic ed,
                          input logic [15:0] er, input logic [3:0] ef);
    chk($sformatf("s%0d_busy", 1 << idx), 32'(b), 32'(eb));
    chk($sformatf("s%0d_done", 1 << idx), 32'(d), 32'(ed));
    chk($sformatf("s%0d_R", 1 << idx), 32'(r), 32'(er));
    chk($sformatf("s%0d_flags", 1 << idx), 32'(f), 32'(ef));
  endtask

  // Single compare process: every cycle, every instance against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      cmp_inst(0, g_dut[0].bus.busy, g_dut[0].bus.done, g_dut[0].bus.R, g_dut[0].bus.flags,
               g_dut[0].exp_busy, g_dut[0].exp_done, g_dut[0].r_exp, g_dut[0].f_exp);
      cmp_inst(1, g_dut[1].bus.busy, g_dut[1].bus.done, g_dut[1].bus.R, g_dut[1].bus.flags,
               g_dut[1].exp_busy, g_dut[1].exp_done, g_dut[1].r_exp, g_dut[1].f_exp);
      cmp_inst(2, g_dut[2].bus.busy, g_dut[2].bus.done, g_dut[2].bus.R, g_dut[2].bus.flags,
               g_dut[2].exp_busy, g_dut[2].exp_done, g_dut[2].r_exp, g_dut[2].f_exp);
      cmp_inst(3, g_dut[3].bus.busy, g_dut[3].bus.done, g_dut[3].bus.R, g_dut[3].bus.flags,
               g_dut[3].exp_busy, g_dut[3].exp_done, g_dut[3].r_exp, g_dut[3].f_exp);
    end
  end

  // One-cycle start pulse; returns at the falling edge after the accepting edge.
  task automatic op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done0(input string name, output int lat, output int nbusy);
    bit seen;
    seen  = 1'b0;
    lat   = 0;
    nbusy = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (g_dut[0].bus.busy === 1'b1) nbusy++;
      if (g_dut[0].bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no done expected done within 30 cycles", name);
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic [15:0] er, input logic [3:0] ef);
    chk({name, "_R_s1"}, 32'(g_dut[0].bus.R), 32'(er));
    chk({name, "_R_s2"}, 32'(g_dut[1].bus.R), 32'(er));
    chk({name, "_R_s4"}, 32'(g_dut[2].bus.R), 32'(er));
    chk({name, "_R_s8"}, 32'(g_dut[3].bus.R), 32'(er));
    chk({name, "_F_s1"}, 32'(g_dut[0].bus.flags), 32'(ef));
    chk({name, "_F_s8"}, 32'(g_dut[3].bus.flags), 32'(ef));
  endtask

  initial begin
    int lat, nb, n0, n1;
    logic [15:0] a;
    logic [7:0]  b;

    repeat (3) @(negedge clk);
    run_chk = 1'b1;
    chk("rst_busy", 32'(g_dut[0].bus.busy), 32'h0);
    chk("rst_done", 32'(g_dut[0].bus.done), 32'h0);
    chk("rst_R", 32'(g_dut[3].bus.R), 32'h0);
    chk("rst_flags", 32'(g_dut[3].bus.flags), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    op(16'h1234, 8'h56);
    wait_done0("basic", lat, nb);
    chk("basic_lat", 32'(lat), 32'd9);
    chk("basic_busy_cycles", 32'(nb), 32'd8);
    settle();
    check_all("basic", 16'h1036, 4'b0000);

    op(16'h00FF, 8'h01);
    settle();
    check_all("sign", 16'h00FF, 4'b1000);

    op(16'h0000, 8'h05);
    settle();
    check_all("zero", 16'h0000, 4'b0001);

    op(16'h5678, 8'h12);
    wait_done0("ovf", lat, nb);
    chk("ovf_lat", 32'(lat), 32'd1);
    chk("ovf_busy_cycles", 32'(nb), 32'd0);
    settle();
    check_all("ovf", 16'h5678, 4'b1100);

    op(16'h00FF, 8'h00);
    wait_done0("dz", lat, nb);
    chk("dz_lat", 32'(lat), 32'd1);
    settle();
    check_all("dz", 16'h00FF, 4'b1100);

    // Extra start pulses at edges k+3 and k+5 of a running divide.
    n0 = g_dut[0].ndone;
    n1 = g_dut[1].ndone;
    op(16'h1234, 8'h56);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 16'hFFFF; divisor = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle();
    chk("ign_ndone_s1", 32'(g_dut[0].ndone - n0), 32'd1);
    chk("ign_ndone_s2", 32'(g_dut[1].ndone - n1), 32'd1);
    chk("ign_R_s1", 32'(g_dut[0].bus.R), 32'h1036);
    chk("ign_R_s2", 32'(g_dut[1].bus.R), 32'h1036);

    // Reset sampled at RUN edge k+4.
    n0 = g_dut[0].ndone;
    op(16'h1234, 8'h56);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(g_dut[0].bus.busy), 32'h0);
    chk("mid_rst_done", 32'(g_dut[0].bus.done), 32'h0);
    chk("mid_rst_R", 32'(g_dut[0].bus.R), 32'h0);
    chk("mid_rst_flags", 32'(g_dut[0].bus.flags), 32'h0);
    reset = 1'b0;
    settle();
    chk("mid_rst_ndone", 32'(g_dut[0].ndone - n0), 32'd0);
    op(16'h1234, 8'h56);
    settle();
    check_all("after_rst", 16'h1036, 4'b0000);

    // Randomized operands, boundary divisors included; the model checks each cycle.
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case (i % 4)
        0:       b = 8'h01;
        1:       b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      if (i % 5 != 4 && b != 8'h00) a[15:8] = a[15:8] % b;
      op(a, b);
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle sequential divider: 16-bit dividend / 8-bit divisor, unsigned restoring algorithm.
- Produces R = {remainder[7:0], quotient[7:0]} plus the 4-bit flag vector, with the same flag bit order the ALU uses: Z=bit0, C=bit1, V=bit2, S=bit3.
- Sits beside the combinational ALU. The CPU microsequencer issues DIV here, waits for done, then writes R and flags back. This removes the single-cycle divider from the ALU critical path.

Parameters:
- STEPS_PER_CYCLE, 1, restoring iterations per clock. Legal values are 1, 2, 4, 8; any other value is a compile-time error.
- Iteration latency NITER = 8/STEPS_PER_CYCLE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- dividend  in  16  A operand. Captured on accept.
- divisor  in  8  B[7:0] operand. Captured on accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; R and flags are valid in this cycle.
- R  out  16  {remainder, quotient}. Holds its value until the next accept.
- flags  out  4  {S,V,C,Z}. Holds its value until the next accept.

Behaviour:
- Reset (synchronous, any state): state=IDLE, busy=0, done=0, R=16'h0000, flags=4'h0. An operation in flight is discarded and no done is issued.
- States: IDLE, RUN, FIN.
- IDLE, start=1 (accept at edge k):
  - Latch the operands.
  - divisor==0 -> go to FIN with the div-by-zero result.
  - Else dividend[15:8] >= divisor -> go to FIN with the overflow result (quotient > 8'hFF).
  - Else go to RUN: rem = dividend[15:8], q = dividend[7:0], iteration count = 0.
- RUN, each cycle, repeated STEPS_PER_CYCLE times:
  - t = {rem, q[7]} (9 bits); q <<= 1.
  - If t >= {1'b0, divisor}: rem = t - divisor, q[0] = 1. Else rem = t[7:0].
  - After NITER cycles, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then return to IDLE. R and flags register on the edge entering FIN.
- Latency:
  - Normal operation: done is high in the cycle after edge k+NITER+1. With STEPS_PER_CYCLE=1, start sampled at edge k gives done visible from edge k+9 to edge k+10.
  - Zero/overflow: done visible from edge k+1.
- busy: high in RUN only. done and busy are never high together.
- Normal result: R = {rem, q}.
  - Z = (R == 16'h0000), i.e. quotient and remainder both zero.
  - C = 0, V = 0, S = q[7].
- Overflow result: R = dividend unchanged; Z=0, C=0, V=1, S=1.
- Div-by-zero result: R = dividend unchanged; Z=0, C=0, V=1, S=1.
- start while busy or in FIN: ignored, with no queuing. The operand inputs may change freely after accept.
- start held high continuously: a new accept occurs in each IDLE cycle. The earliest is the cycle after the done pulse, because FIN returns to IDLE.
- No signed mode and no abort port; reset is the only cancel.

Test Plan:
- Basic divide: reset, then start dividend=16'h1234, divisor=8'h56 (STEPS=1). Required: busy high for 8 cycles; done pulses at edge k+9; R=16'h1036 (q=0x36, r=0x10); flags=4'b0000.
- Sign flag: dividend=16'h00FF, divisor=8'h01. Required: R=16'h00FF, flags: S=1, Z=0, V=0, C=0 (4'b1000).
- Zero result: dividend=16'h0000, divisor=8'h05. Required: after full latency, R=16'h0000, Z=1, other flags 0.
- Overflow and div-by-zero:
  - dividend=16'h5678, divisor=8'h12: done at edge k+1, busy never high, R=16'h5678, flags=4'b1100.
  - dividend=16'h00FF, divisor=8'h00: same timing, R=16'h00FF, flags=4'b1100.
- Ignored start: pulse start with dividend=16'hFFFF, divisor=8'h01 at cycles 3 and 5 of the 16'h1234/8'h56 run. Required: a single done only, R=16'h1036. R and flags stay held until the next accept.
- Reset mid-operation: assert reset at RUN cycle 4. Required: the next cycle shows busy=0, R=0, flags=0, and no done. A new start then completes normally.
- Sweep: repeat all of the above with STEPS_PER_CYCLE=2, 4, 8. Required: latency NITER+1 and identical results. Also run randomized operands against a reference model, covering the boundary divisors 8'h01 and 8'hFF.
